// File: rtl/key_set_ctrl.sv
// key_set_ctrl: edit-mode sequencer for the digital clock.
// Decodes MODE/UP/DOWN key_filter events, steps RUN->SET_HOUR->SET_MIN->SET_SEC,
// emits single-cycle inc/dec pulses with long-press auto-repeat, drives the
// edit-digit blink and falls back to RUN after a period of inactivity.
module key_set_ctrl #(
  parameter int unsigned LONG_CYC    = 50_000_000,
  parameter int unsigned REP_CYC     = 10_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned BLINK_CYC   = 25_000_000,
  parameter int unsigned CNT_W       = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_flag,
  input  logic       mode_state,
  input  logic       up_flag,
  input  logic       up_state,
  input  logic       dn_flag,
  input  logic       dn_state,
  output logic [1:0] set_mode,
  output logic       run_en,
  output logic       inc,
  output logic       dec,
  output logic       blink,
  output logic       set_done
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOUR = 2'd1,
    ST_MIN  = 2'd2,
    ST_SEC  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    TRK_NONE = 2'd0,
    TRK_UP   = 2'd1,
    TRK_DN   = 2'd2
  } trk_t;

  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(LONG_CYC - REP_CYC);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] BLK_LAST   = CNT_W'(BLINK_CYC - 1);

  mode_t            r_state, w_state_nxt;
  trk_t             r_trk, w_trk_nxt;
  logic [CNT_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [CNT_W-1:0] r_blk_cnt, w_blk_cnt_nxt;
  logic             r_inc, w_inc_nxt;
  logic             r_dec, w_dec_nxt;
  logic             r_blink, w_blink_nxt;
  logic             r_set_done, w_set_done_nxt;
  logic             r_run_en, w_run_en_nxt;

  logic w_mode_press, w_up_press, w_up_rel, w_dn_press, w_dn_rel, w_any_flag;
  logic w_in_set, w_to_hit, w_mode_chg, w_hold_keep, w_trk_rel;

  assign w_mode_press = mode_flag & ~mode_state;
  assign w_up_press   = up_flag & ~up_state;
  assign w_up_rel     = up_flag & up_state;
  assign w_dn_press   = dn_flag & ~dn_state;
  assign w_dn_rel     = dn_flag & dn_state;
  assign w_any_flag   = mode_flag | up_flag | dn_flag;

  assign w_in_set    = (r_state != ST_RUN);
  assign w_to_hit    = w_in_set && (r_to_cnt == TO_LAST);
  assign w_mode_chg  = (w_state_nxt != r_state);
  // Hold tracking survives only while staying in SET without a MODE press or timeout.
  assign w_hold_keep = w_in_set && !w_mode_press && !w_to_hit;
  assign w_trk_rel   = ((r_trk == TRK_UP) && w_up_rel) || ((r_trk == TRK_DN) && w_dn_rel);

  // Mode FSM next state: MODE press advances, otherwise inactivity timeout returns to RUN.
  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_press) begin
      case (r_state)
        ST_RUN:  w_state_nxt = ST_HOUR;
        ST_HOUR: w_state_nxt = ST_MIN;
        ST_MIN:  w_state_nxt = ST_SEC;
        default: w_state_nxt = ST_RUN;
      endcase
    end else if (w_to_hit) begin
      w_state_nxt = ST_RUN;
    end
  end

  // Inactivity counter: held at 0 in RUN, cleared on any key event or mode change.
  always_comb begin
    w_to_cnt_nxt = r_to_cnt + 1'b1;
    if ((w_state_nxt == ST_RUN) || w_mode_chg || w_any_flag)
      w_to_cnt_nxt = '0;
  end

  // UP/DOWN hold tracking and inc/dec pulse generation.
  // After the first long-press pulse the hold counter is reloaded to LONG-REP,
  // so every later pulse again fires at LONG-1 and the period becomes REP.
  always_comb begin
    w_trk_nxt      = r_trk;
    w_hold_cnt_nxt = r_hold_cnt;
    w_inc_nxt      = 1'b0;
    w_dec_nxt      = 1'b0;
    if (!w_hold_keep) begin
      w_trk_nxt      = TRK_NONE;
      w_hold_cnt_nxt = '0;
    end else if (r_trk == TRK_NONE) begin
      if (w_up_press) begin
        w_trk_nxt      = TRK_UP;
        w_hold_cnt_nxt = '0;
        w_inc_nxt      = 1'b1;
      end else if (w_dn_press) begin
        w_trk_nxt      = TRK_DN;
        w_hold_cnt_nxt = '0;
        w_dec_nxt      = 1'b1;
      end
    end else if (w_trk_rel) begin
      w_trk_nxt      = TRK_NONE;
      w_hold_cnt_nxt = '0;
    end else if (r_hold_cnt == LONG_LAST) begin
      w_hold_cnt_nxt = REP_RELOAD;
      w_inc_nxt      = (r_trk == TRK_UP);
      w_dec_nxt      = (r_trk == TRK_DN);
    end else begin
      w_hold_cnt_nxt = r_hold_cnt + 1'b1;
    end
  end

  // Blink: off in RUN, forced on at mode change or adjust pulse, else toggles each half-period.
  always_comb begin
    w_blink_nxt   = r_blink;
    w_blk_cnt_nxt = r_blk_cnt + 1'b1;
    if (w_state_nxt == ST_RUN) begin
      w_blink_nxt   = 1'b0;
      w_blk_cnt_nxt = '0;
    end else if (w_mode_chg || w_inc_nxt || w_dec_nxt) begin
      w_blink_nxt   = 1'b1;
      w_blk_cnt_nxt = '0;
    end else if (r_blk_cnt == BLK_LAST) begin
      w_blink_nxt   = ~r_blink;
      w_blk_cnt_nxt = '0;
    end
  end

  // Status flags derived from the upcoming mode.
  always_comb begin
    w_run_en_nxt   = (w_state_nxt == ST_RUN);
    w_set_done_nxt = w_in_set && (w_state_nxt == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_trk      <= TRK_NONE;
      r_to_cnt   <= '0;
      r_hold_cnt <= '0;
      r_blk_cnt  <= '0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_blink    <= 1'b0;
      r_set_done <= 1'b0;
      r_run_en   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_trk      <= w_trk_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_blk_cnt  <= w_blk_cnt_nxt;
      r_inc      <= w_inc_nxt;
      r_dec      <= w_dec_nxt;
      r_blink    <= w_blink_nxt;
      r_set_done <= w_set_done_nxt;
      r_run_en   <= w_run_en_nxt;
    end
  end

  assign set_mode = r_state;
  assign run_en   = r_run_en;
  assign inc      = r_inc;
  assign dec      = r_dec;
  assign blink    = r_blink;
  assign set_done = r_set_done;

endmodule

// File: tb/tb_key_set_ctrl.sv
// Self-checking bench for key_set_ctrl with a time-based reference model.
module tb_key_set_ctrl;

  localparam int LONG = 20;
  localparam int REP  = 5;
  localparam int TMO  = 100;
  localparam int BLK  = 8;
  localparam logic [6:0] RST_VEC = 7'b00_1_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode_flag = 1'b0, mode_state = 1'b1;
  logic up_flag = 1'b0, up_state = 1'b1;
  logic dn_flag = 1'b0, dn_state = 1'b1;
  logic [1:0] set_mode;
  logic run_en, inc, dec, blink, set_done;

  key_set_ctrl #(
    .LONG_CYC(LONG), .REP_CYC(REP), .TIMEOUT_CYC(TMO), .BLINK_CYC(BLK), .CNT_W(29)
  ) dut (
    .clk(clk), .rst(rst),
    .mode_flag(mode_flag), .mode_state(mode_state),
    .up_flag(up_flag), .up_state(up_state),
    .dn_flag(dn_flag), .dn_state(dn_state),
    .set_mode(set_mode), .run_en(run_en), .inc(inc), .dec(dec),
    .blink(blink), .set_done(set_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model: mode number, tracked key (0 none, 1 up, 2 down), press time,
  // cycle at which the timeout count was last zero, cycle at which blink was last forced on.
  int m_mode = 0, m_trk = 0, m_tp = 0, m_zero = 0, m_bref = 0;
  logic [6:0] m_exp = RST_VEC;

  function automatic logic [6:0] dut_vec();
    return {set_mode, run_en, inc, dec, blink, set_done};
  endfunction

  // Expected outputs for cycle k from the inputs sampled at the edge starting it.
  function automatic void model_step();
    int k, p, cm, nm, d;
    bit mp, upp, upr, dnp, dnr, anyf, to, pi, pd, bl, sd;
    k = cyc;
    p = cyc - 1;
    if (rst) begin
      m_mode = 0; m_trk = 0; m_zero = k; m_bref = k; m_exp = RST_VEC;
      return;
    end
    mp   = mode_flag && !mode_state;
    upp  = up_flag && !up_state;
    upr  = up_flag && up_state;
    dnp  = dn_flag && !dn_state;
    dnr  = dn_flag && dn_state;
    anyf = mode_flag || up_flag || dn_flag;
    cm   = m_mode;
    to   = (cm != 0) && ((p - m_zero) == TMO - 1) && !mp;
    nm   = mp ? (cm + 1) % 4 : (to ? 0 : cm);
    pi = 0; pd = 0;
    if (cm == 0 || mp || to) m_trk = 0;
    else if (m_trk == 0) begin
      if (upp) begin m_trk = 1; m_tp = p; pi = 1; end
      else if (dnp) begin m_trk = 2; m_tp = p; pd = 1; end
    end else if ((m_trk == 1 && upr) || (m_trk == 2 && dnr)) m_trk = 0;
    else begin
      d = k - (m_tp + 1);
      if (d >= LONG && ((d - LONG) % REP) == 0) begin
        if (m_trk == 1) pi = 1; else pd = 1;
      end
    end
    if (nm != cm || anyf || nm == 0) m_zero = k;
    if (nm == 0) bl = 0;
    else if (nm != cm || pi || pd) begin m_bref = k; bl = 1; end
    else bl = (((k - m_bref) / BLK) % 2) == 0;
    sd = (cm != 0) && (nm == 0);
    m_mode = nm;
    m_exp = {2'(nm), (nm == 0), pi, pd, bl, sd};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    mode_flag = 1'b0;
    up_flag   = 1'b0;
    dn_flag   = 1'b0;
  endtask

  task automatic key_mode(input bit down); mode_flag = 1'b1; mode_state = !down; endtask
  task automatic key_up(input bit down);   up_flag   = 1'b1; up_state   = !down; endtask
  task automatic key_dn(input bit down);   dn_flag   = 1'b1; dn_state   = !down; endtask

  task automatic do_reset();
    rst = 1'b1;
    mode_state = 1'b1; up_state = 1'b1; dn_state = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mode_flag = 1'($urandom_range(0, 1));
      up_flag   = 1'($urandom_range(0, 1));
      dn_flag   = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (dut_vec() !== RST_VEC) begin
        fails++;
        $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, dut_vec(), RST_VEC);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_mode_cycle();
    logic [1:0] seq [4];
    int hold;
    seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int n = 0; n < 4; n++) begin
      hold = $urandom_range(1, 6);
      for (int i = 0; i < 10; i++) begin
        if (i == 0) key_mode(1);
        if (i == hold) key_mode(0);
        tick();
        checks++;
        if (dut_vec() !== m_exp) begin
          fails++;
          $display("FAIL mode_cycle_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_exp);
        end
        if (i == 0) begin
          checks++;
          if ({set_mode, set_done, run_en} !== {seq[n], n == 3, n == 3}) begin
            fails++;
            $display("FAIL mode_step%0d got=%b exp=%b", n, {set_mode, set_done, run_en},
                     {seq[n], n == 3, n == 3});
          end
        end
      end
    end
  endtask

  task automatic test_hold_repeat();
    int tp, rel;
    logic [63:0] mask, emask;
    bit dec_seen;
    mask = '0; emask = '0; dec_seen = 0;
    emask[1] = 1'b1; emask[21] = 1'b1; emask[26] = 1'b1; emask[31] = 1'b1; emask[36] = 1'b1;
    tp = 8 + $urandom_range(0, 7);
    do_reset();
    for (int i = 0; i <= tp + 60; i++) begin
      if (i == 0 || i == 3) key_mode(1);
      if (i == 1 || i == 4) key_mode(0);
      if (i == tp) key_up(1);
      if (i == tp + 40) key_up(0);
      tick();
      checks++;
      if (dut_vec() !== m_exp) begin
        fails++;
        $display("FAIL hold_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_exp);
      end
      rel = i + 1 - tp;
      if (rel >= 0 && rel < 64) mask[rel] = inc;
      if (dec) dec_seen = 1;
    end
    checks++;
    if (mask !== emask) begin
      fails++;
      $display("FAIL hold_inc_times got=%h exp=%h", mask, emask);
    end
    checks++;
    if (dec_seen !== 1'b0) begin
      fails++;
      $display("FAIL hold_no_dec got=%b exp=0", dec_seen);
    end
  endtask

  task automatic test_up_dn_priority();
    int b, inc_cnt, dec_early;
    bit dec_fresh;
    b = $urandom_range(4, 8);
    inc_cnt = 0; dec_early = 0; dec_fresh = 0;
    do_reset();
    for (int i = 0; i <= b + 55; i++) begin
      if (i == 0) key_mode(1);
      if (i == 1) key_mode(0);
      if (i == b) begin key_up(1); key_dn(1); end
      if (i == b + 3) key_dn(0);
      if (i == b + 8) key_dn(1);
      if (i == b + 30) key_up(0);
      if (i == b + 40) key_dn(0);
      if (i == b + 45) key_dn(1);
      if (i == b + 50) key_dn(0);
      tick();
      checks++;
      if (dut_vec() !== m_exp) begin
        fails++;
        $display("FAIL prio_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_exp);
      end
      if (inc) inc_cnt++;
      if (dec && i < b + 45) dec_early++;
      if (i == b + 45) dec_fresh = dec;
    end
    checks++;
    if (inc_cnt != 3) begin
      fails++;
      $display("FAIL prio_inc_count got=%0d exp=3", inc_cnt);
    end
    checks++;
    if (dec_early != 0) begin
      fails++;
      $display("FAIL prio_dec_ignored got=%0d exp=0", dec_early);
    end
    checks++;
    if (dec_fresh !== 1'b1) begin
      fails++;
      $display("FAIL prio_fresh_dec got=%b exp=1", dec_fresh);
    end
  endtask

  task automatic test_timeout();
    int r;
    do_reset();
    for (int i = 0; i <= 112; i++) begin
      if (i == 0 || i == 3 || i == 6) key_mode(1);
      if (i == 1 || i == 4 || i == 7) key_mode(0);
      tick();
      checks++;
      if (dut_vec() !== m_exp) begin
        fails++;
        $display("FAIL timeout_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_exp);
      end
      if (i == 106 || i == 107) begin
        checks++;
        if ({set_mode, set_done} !== ((i == 106) ? 3'b11_0 : 3'b00_1)) begin
          fails++;
          $display("FAIL timeout_edge i=%0d got=%b exp=%b", i, {set_mode, set_done},
                   (i == 106) ? 3'b11_0 : 3'b00_1);
        end
      end
    end
    // Untracked UP release late in SET restarts the inactivity window.
    r = 3 + $urandom_range(85, 95);
    for (int j = 0; j <= r + 105; j++) begin
      if (j == 0) key_up(1);
      if (j == 2) key_mode(1);
      if (j == 3) key_mode(0);
      if (j == r) key_up(0);
      tick();
      checks++;
      if (dut_vec() !== m_exp) begin
        fails++;
        $display("FAIL timeout_restart_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_exp);
      end
      if (j == r + 99 || j == r + 100) begin
        checks++;
        if ({set_mode, set_done} !== ((j == r + 99) ? 3'b01_0 : 3'b00_1)) begin
          fails++;
          $display("FAIL timeout_restart_edge j=%0d got=%b exp=%b", j, {set_mode, set_done},
                   (j == r + 99) ? 3'b01_0 : 3'b00_1);
        end
      end
    end
  endtask

  task automatic test_run_and_mode_cancel();
    int bad, b, dec_cnt, dec_late;
    logic [1:0] mode_after;
    bad = 0; dec_cnt = 0; dec_late = 0; mode_after = 2'd0;
    do_reset();
    for (int i = 0; i <= 55; i++) begin
      if (i == 0) key_up(1);
      if (i == 50) key_up(0);
      tick();
      checks++;
      if (dut_vec() !== m_exp) begin
        fails++;
        $display("FAIL run_ignore_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_exp);
      end
      if (inc || dec || blink) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL run_ignore_activity got=%0d exp=0", bad);
    end
    b = $urandom_range(3, 6);
    for (int j = 0; j <= b + 60; j++) begin
      if (j == 0 || j == b + 25) key_mode(1);
      if (j == 1 || j == b + 26) key_mode(0);
      if (j == b) key_dn(1);
      if (j == b + 56) key_dn(0);
      tick();
      checks++;
      if (dut_vec() !== m_exp) begin
        fails++;
        $display("FAIL mode_cancel_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_exp);
      end
      if (dec) dec_cnt++;
      if (dec && j >= b + 25) dec_late++;
      if (j == b + 25) mode_after = set_mode;
    end
    checks++;
    if ({dec_cnt, dec_late} != {32'd2, 32'd0}) begin
      fails++;
      $display("FAIL mode_cancel_dec got=%0d/%0d exp=2/0", dec_cnt, dec_late);
    end
    checks++;
    if (mode_after !== 2'd2) begin
      fails++;
      $display("FAIL mode_cancel_advance got=%0d exp=2", mode_after);
    end
  endtask

  task automatic test_reset_mid_hold();
    int b, late;
    b = $urandom_range(3, 6);
    late = 0;
    do_reset();
    for (int j = 0; j <= b + 65; j++) begin
      rst = (j == b + 30);
      if (j == 0) key_mode(1);
      if (j == 1) key_mode(0);
      if (j == b) key_up(1);
      if (j == b + 60) key_up(0);
      tick();
      checks++;
      if (dut_vec() !== m_exp) begin
        fails++;
        $display("FAIL rst_hold_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_exp);
      end
      if (j == b + 30) begin
        checks++;
        if (dut_vec() !== RST_VEC) begin
          fails++;
          $display("FAIL rst_hold_values got=%b exp=%b", dut_vec(), RST_VEC);
        end
      end
      if (j > b + 30 && (inc || dec)) late++;
    end
    rst = 1'b0;
    checks++;
    if (late != 0) begin
      fails++;
      $display("FAIL rst_hold_no_pulse got=%0d exp=0", late);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ((i % 400) < 250) begin
        r = $urandom_range(0, 99);
        if (r < 2) key_mode(mode_state);
        else if (r < 8) key_up(up_state);
        else if (r < 14) key_dn(dn_state);
        else if (r == 14) begin key_up(up_state); key_dn(dn_state); end
        else if (r == 15) begin key_mode(mode_state); key_up(up_state); end
      end
      tick();
      checks++;
      if (dut_vec() !== m_exp) begin
        fails++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_exp);
      end
      checks++;
      if ((inc && dec) !== 1'b0) begin
        fails++;
        $display("FAIL random_inc_dec_excl cyc=%0d got=%b%b exp=not both", cyc, inc, dec);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_hold_repeat();
    test_up_dn_priority();
    test_timeout();
    test_run_and_mode_cancel();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
